// File: rtl/timer_pkg.sv
// Shared constants and elaboration-time helpers for the timer/front-panel controller.
package timer_pkg;

  localparam int NCH_MAX = 8;
  localparam int DB_MIN  = 2;

  // Half-period length in bus clocks.
  function automatic int half_cnt(input int clk_hz, input int tick_hz);
    return clk_hz / (2 * tick_hz);
  endfunction

  // Width of the half-period counter; never narrower than one bit.
  function automatic int cnt_w(input int half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/tbtn_debounce.sv
// One front-panel button: optional synchronizer (TIMER_BTN_SYNC_EN), tick-sampled
// shift register and re-arm flag. Emits a one-cycle toggle request.
module tbtn_debounce
  import timer_pkg::*;
#(
  parameter int DEPTH = DB_MIN
) (
  input  logic clk_p,
  input  logic dclo,
  input  logic btn,
  input  logic tick,
  output logic toggle_req
);

  logic btn_s;

`ifdef TIMER_BTN_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_p) begin
    if (dclo) sync_q <= '0;
    else      sync_q <= {sync_q[0], btn};
  end

  assign btn_s = sync_q[1];
`else
  assign btn_s = btn;
`endif

  logic [DEPTH-1:0] sh_q, sh_d, nsh;
  logic             armed_q, armed_d;

  // A press is honoured only after the line has been seen fully low since the last press.
  always_comb begin
    nsh        = {sh_q[DEPTH-2:0], btn_s};
    sh_d       = sh_q;
    armed_d    = armed_q;
    toggle_req = 1'b0;
    if (tick) begin
      sh_d = nsh;
      if (&nsh) begin
        toggle_req = armed_q;
        armed_d    = 1'b0;
      end else if (~|nsh) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      sh_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/timer_ctl.sv
// Timer square wave / tick generator plus per-channel button-toggled enables and
// gated event lines. Define TIMER_BTN_SYNC_EN to synchronize asynchronous buttons.
module timer_ctl
  import timer_pkg::*;
#(
  parameter int             CLK_HZ      = 100000000,
  parameter int             TICK_HZ     = 50,
  parameter int             NCH         = 2,
  parameter int             DB_DEPTH    = 2,
  parameter logic [NCH-1:0] STATUS_INIT = '0
) (
  input  logic           clk_p,
  input  logic           dclo,
  input  logic [NCH-1:0] btn,
  input  logic [NCH-1:0] st_set,
  input  logic [NCH-1:0] st_clr,
  output logic           tick_o,
  output logic           wave_o,
  output logic [NCH-1:0] status,
  output logic [NCH-1:0] evnt,
  output logic [NCH-1:0] toggled
);

  localparam int              HALF    = half_cnt(CLK_HZ, TICK_HZ);
  localparam int              HC_W    = cnt_w(HALF);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF - 1);

  if (NCH < 1 || NCH > NCH_MAX || DB_DEPTH < DB_MIN || HALF < 2) begin : g_bad_cfg
    $error("timer_ctl: parameter out of range");
  end

  logic [HC_W-1:0] hc_q, hc_d;
  logic            wave_q, wave_d, tick_q, tick_d;
  logic [NCH-1:0]  status_q, status_d, evnt_q, toggled_q, toggled_d, req;

  // hc back at zero with the wave high means the wave rose on the previous edge.
  always_comb begin
    hc_d   = hc_q + 1'b1;
    wave_d = wave_q;
    if (hc_q == HC_LAST) begin
      hc_d   = '0;
      wave_d = ~wave_q;
    end
    tick_d = (hc_q == '0) && wave_q;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tbtn_debounce #(.DEPTH(DB_DEPTH)) u_db (
      .clk_p      (clk_p),
      .dclo       (dclo),
      .btn        (btn[i]),
      .tick       (tick_q),
      .toggle_req (req[i])
    );
  end

  // Software clear beats software set beats the button.
  always_comb begin
    status_d  = status_q;
    toggled_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (st_clr[i]) begin
        status_d[i] = 1'b0;
      end else if (st_set[i]) begin
        status_d[i] = 1'b1;
      end else if (req[i]) begin
        status_d[i]  = ~status_q[i];
        toggled_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      hc_q      <= '0;
      wave_q    <= 1'b0;
      tick_q    <= 1'b0;
      status_q  <= STATUS_INIT;
      evnt_q    <= '0;
      toggled_q <= '0;
    end else begin
      hc_q      <= hc_d;
      wave_q    <= wave_d;
      tick_q    <= tick_d;
      status_q  <= status_d;
      evnt_q    <= {NCH{wave_q}} & status_q;
      toggled_q <= toggled_d;
    end
  end

  assign tick_o  = tick_q;
  assign wave_o  = wave_q;
  assign status  = status_q;
  assign evnt    = evnt_q;
  assign toggled = toggled_q;

endmodule

// File: tb/tb_timer_ctl.sv
// Directed bench for timer_ctl: HALF=10, two channels, depth-2 debounce, STATUS_INIT=01.
module tb_timer_ctl;

  localparam int HALF = 10;
  localparam int DB   = 2;
  localparam logic [1:0] S_INIT = 2'b01;

  logic       clk = 1'b0;
  logic       dclo = 1'b1;
  logic [1:0] btn = '0, st_set = '0, st_clr = '0;
  logic       tick_o, wave_o;
  logic [1:0] status, evnt, toggled;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_ctl #(
    .CLK_HZ(1000), .TICK_HZ(50), .NCH(2), .DB_DEPTH(DB), .STATUS_INIT(S_INIT)
  ) dut (
    .clk_p(clk), .dclo(dclo), .btn(btn), .st_set(st_set), .st_clr(st_clr),
    .tick_o(tick_o), .wave_o(wave_o), .status(status), .evnt(evnt), .toggled(toggled)
  );

  // Model: wave/tick from the cycle count since reset, debounce from run lengths.
  logic       m_valid = 1'b0;
  int         n = 0;
  logic       m_wave = 1'b0, m_tick = 1'b0;
  logic [1:0] m_status = '0, m_evnt = '0, m_toggled = '0, m_armed = '0;
  int         ones_run[2];
  int         zeros_run[2];

  always @(posedge clk) begin : model
    logic [1:0] req, nst;
    int o, z, nn;
    if (dclo) begin
      m_valid   <= 1'b1;
      n         <= 0;
      m_wave    <= 1'b0;
      m_tick    <= 1'b0;
      m_status  <= S_INIT;
      m_evnt    <= '0;
      m_toggled <= '0;
      m_armed   <= '0;
      for (int i = 0; i < 2; i++) begin
        ones_run[i]  <= 0;
        zeros_run[i] <= DB;
      end
    end else begin
      req = '0;
      for (int i = 0; i < 2; i++) begin
        if (m_tick) begin
          if (btn[i]) begin o = ones_run[i] + 1; z = 0; end
          else        begin o = 0; z = zeros_run[i] + 1; end
          ones_run[i]  <= o;
          zeros_run[i] <= z;
          if (o >= DB) begin
            req[i]     = m_armed[i];
            m_armed[i] <= 1'b0;
          end else if (z >= DB) begin
            m_armed[i] <= 1'b1;
          end
        end
      end
      nst = m_status;
      for (int i = 0; i < 2; i++) begin
        if (st_clr[i])      nst[i] = 1'b0;
        else if (st_set[i]) nst[i] = 1'b1;
        else if (req[i])    nst[i] = ~nst[i];
      end
      m_toggled <= req & ~st_set & ~st_clr;
      m_evnt    <= {2{m_wave}} & m_status;
      m_status  <= nst;
      nn = n + 1;
      n      <= nn;
      m_wave <= ((nn / HALF) % 2) == 1;
      m_tick <= (nn % (2 * HALF)) == (HALF + 1);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    if (m_valid) begin
      chk("tick_o", 8'(tick_o), 8'(m_tick));
      chk("wave_o", 8'(wave_o), 8'(m_wave));
      chk("status", 8'(status), 8'(m_status));
      chk("evnt", 8'(evnt), 8'(m_evnt));
      chk("toggled", 8'(toggled), 8'(m_toggled));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  // Drive btn during the next tick cycle so the following edge samples it.
  task automatic at_tick(input logic [1:0] b);
    int k;
    k = 0;
    step();
    while (!m_tick && k < 100) begin
      step();
      k++;
    end
    if (!m_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_wait: no tick within %0d cycles", k);
    end
    btn = b;
  endtask

  initial begin : stim
    int k;
    // reset values
    step();
    step();
    chk("rst_tick", 8'(tick_o), 8'd0);
    chk("rst_wave", 8'(wave_o), 8'd0);
    chk("rst_status", 8'(status), 8'h01);
    chk("rst_evnt", 8'(evnt), 8'd0);
    chk("rst_toggled", 8'(toggled), 8'd0);

    // release, clear channel 0, free-run the timer
    dclo   = 1'b0;
    st_clr = 2'b01;
    step();
    st_clr = 2'b00;
    chk("clr_status", 8'(status), 8'h00);
    for (int c = 2; c <= 45; c++) begin
      step();
      if (c == 10) chk("wave_rise", 8'(wave_o), 8'd1);
      if (c == 11) chk("tick_pulse", 8'(tick_o), 8'd1);
      if (c == 20) chk("wave_fall", 8'(wave_o), 8'd0);
    end

    // channel 0 press: low 2 ticks, high 2 ticks
    at_tick(2'b00);
    at_tick(2'b00);
    at_tick(2'b01);
    at_tick(2'b01);
    step();
    chk("press_status", 8'(status), 8'h01);
    chk("press_toggled", 8'(toggled), 8'h01);
    step();
    chk("press_toggled_end", 8'(toggled), 8'h00);
    at_tick(2'b01);
    at_tick(2'b01);

    // channel 1 single-tick glitches while channel 0 stays held
    for (int g = 0; g < 3; g++) begin
      at_tick(2'b11);
      at_tick(2'b01);
    end
    step();
    chk("glitch_status", 8'(status), 8'h01);

    // button held through reset
    dclo = 1'b1;
    step();
    step();
    dclo = 1'b0;
    at_tick(2'b01);
    at_tick(2'b01);
    step();
    chk("held_status", 8'(status), 8'h01);
    at_tick(2'b00);
    at_tick(2'b00);
    at_tick(2'b01);
    at_tick(2'b01);
    step();
    chk("rearm_status", 8'(status), 8'h00);
    chk("rearm_toggled", 8'(toggled), 8'h01);

    // set and clear collide with a toggle request
    at_tick(2'b00);
    at_tick(2'b00);
    at_tick(2'b01);
    at_tick(2'b01);
    st_set = 2'b01;
    st_clr = 2'b01;
    step();
    st_set = 2'b00;
    st_clr = 2'b00;
    chk("prio_status", 8'(status), 8'h00);
    chk("prio_toggled", 8'(toggled), 8'h00);

    // both enabled, then reset mid-period while the wave is high
    st_set = 2'b11;
    step();
    st_set = 2'b00;
    chk("set_status", 8'(status), 8'h03);
    k = 0;
    while (!m_wave && k < 50) begin
      step();
      k++;
    end
    if (!m_wave) begin
      checks++;
      errors++;
      $display("FAIL wave_wait: wave stayed low for %0d cycles", k);
    end
    step();
    step();
    dclo = 1'b1;
    step();
    chk("mid_rst_status", 8'(status), 8'h01);
    chk("mid_rst_wave", 8'(wave_o), 8'd0);
    chk("mid_rst_evnt", 8'(evnt), 8'd0);
    dclo = 1'b0;
    for (int c = 0; c < 30; c++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ctl.md
# timer_ctl

Parametrised timer-interrupt and front-panel toggle controller for the processor module. It runs entirely in the bus clock domain and uses a clock-enable tick, not a derived clock. It generates the periodic timer square wave and a one-cycle tick, and debounces NCH front-panel buttons, each of which toggles a per-channel enable. Its outputs are per-channel gated event lines feeding the CPU event input and other periodic-interrupt consumers. Register-driven set/clear inputs allow software control alongside the buttons.

## Interface
Parameters:
- CLK_HZ, 100000000, bus clock frequency.
- TICK_HZ, 50, timer frequency.
- NCH, 2, number of button/enable channels (1..8).
- DB_DEPTH, 2, consecutive tick samples required for a stable level (2..8).
- STATUS_INIT, 0 (NCH bits), status value loaded by reset.

Ports:
- clk_p  in  1  bus clock.
- dclo  in  1  reset: one clock; reset is synchronous and active-high.
- btn  in  NCH  raw button levels, 1 = pressed.
- st_set  in  NCH  one-cycle pulse that forces status[i] to 1.
- st_clr  in  NCH  one-cycle pulse that forces status[i] to 0.
- tick_o  out  1  one-cycle pulse at TICK_HZ.
- wave_o  out  1  TICK_HZ square wave, 50% duty.
- status  out  NCH  per-channel enable.
- evnt  out  NCH  registered wave_o & status[i].
- toggled  out  NCH  one-cycle pulse when a button toggles status[i].

## Operation
- HALF = CLK_HZ/(2*TICK_HZ), integer division; HALF must be at least 2.
  - Half-period counter hc has width $clog2(HALF) and counts 0..HALF-1.
  - When hc reaches HALF-1, hc wraps to 0 and wave_o inverts.
- tick_o asserts in the cycle after wave_o rises 0->1, so one pulse per full period.
- Per channel, a shift register sh[DB_DEPTH-1:0] samples btn only on tick_o cycles: sh <= {sh[DB_DEPTH-2:0], btn_s}.
- Debounce evaluation uses the new shift value nsh.
  - If nsh is all ones and armed = 1: request a toggle, then armed <= 0.
  - If nsh is all zeros: armed <= 1.
  - Any mixed value: armed holds.
- Status update priority per channel, same cycle: st_clr > st_set > toggle request.
  - A toggle request that loses to set/clr is discarded. armed still clears and toggled does not pulse.
  - When the toggle wins, status[i] <= ~status[i] and toggled[i] pulses for one cycle.
- evnt[i] <= wave_o & status[i], registered.
- Channels are fully independent. Simultaneous toggles on several channels are all honoured.
- Reset values:
  - hc = 0, wave_o = 0, tick_o = 0
  - sh = 0, armed = 0. A button held through reset must be released for DB_DEPTH ticks before it can toggle.
  - status = STATUS_INIT, evnt = 0, toggled = 0
  - synchronizer flops = 0
- Reset asserted mid-operation aborts debounce and count immediately at the next edge. It overrides set/clr.

## Timing
- wave_o period is 2*HALF cycles. tick_o follows the wave_o rising edge by 1 cycle.
- A button toggle takes effect at the clock edge of the DB_DEPTH-th consecutive tick on which btn_s = 1. status and toggled change on that same edge.
- st_set/st_clr change status one cycle after the pulse. evnt follows status or wave_o changes with 1 further cycle of latency.
- A set/clr pulse lasting more than one cycle simply re-applies; this is harmless.

## Configuration
- TIMER_BTN_SYNC_EN defined:
  - btn_s is btn passed through a two-flop synchronizer per channel, adding 2 cycles of latency to sampling.
  - Required when the buttons are asynchronous pins.
- TIMER_BTN_SYNC_EN undefined:
  - btn_s = btn directly.
  - The source must already be synchronous to clk_p.

## Structure
- Package timer_pkg holds:
  - function half_cnt(clk_hz, tick_hz) returning HALF
  - the counter-width localparam derivation
  - constants NCH_MAX = 8 and DB_MIN = 2
- Sub-module tbtn_debounce, one instance per channel via generate:
  - contains the synchronizer, shift register and armed flag
  - inputs: clk_p, dclo, btn, tick; output: one-cycle toggle request
  - status priority logic and evnt gating stay in timer_ctl

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=50 (HALF=10), NCH=2, DB_DEPTH=2, no sync macro.
- Release dclo -> wave_o toggles every 10 cycles. tick_o pulses every 20 cycles, 1 cycle after each wave_o rise. status = 0, evnt = 0.
- Hold btn[0] low for 2 ticks, then high for 2 ticks -> status[0] 0->1 at the 2nd high tick. toggled[0] pulses once. Continued hold causes no further toggles. evnt[0] follows wave_o delayed 1 cycle.
- Apply btn[1] glitches high for 1 tick, alternating with low -> status[1] never changes.
- Hold btn[0] high through reset -> no toggle until btn is low for 2 ticks, then high for 2 ticks.
- Pulse st_set[0] and st_clr[0] in the same cycle as a button toggle request -> status[0] = 0 next cycle, toggled[0] = 0.
- Assert dclo mid-period while status = 2'b11 and STATUS_INIT = 2'b01 -> next cycle: status = 01, wave_o = 0, hc = 0, evnt = 0.
